alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 106 ++++++++++
 tb/tb_alu_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// Two-requester front end for a shared 4-bit ALU: arbitrates, registers the operands, captures the result.
// Define ALU_CTRL_RR_EN for round-robin arbitration; the default build is fixed priority with requester 0 first.
module alu_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_sel,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [3:0] alu_out,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_data,
  output logic       rsp_carry,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   accept;
  logic   grant_id;

`ifdef ALU_CTRL_RR_EN
  logic last_grant_q;

  // Reset value 1 makes requester 0 the winner of the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant_q <= 1'b1;
    else if (accept) last_grant_q <= grant_id;
  end
`endif

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    grant_id = req1_valid & ~req0_valid;
    if (req0_valid && req1_valid) begin
`ifdef ALU_CTRL_RR_EN
      grant_id = ~last_grant_q;
`else
      grant_id = 1'b0;
`endif
    end
  end

  assign accept = (state_q == IDLE) && (req0_valid || req1_valid);

  // Ready is combinational from the requests, so it is gated with rst_n to read 0 throughout reset.
  assign req0_ready = rst_n && accept && !grant_id;
  assign req1_ready = rst_n && accept &&  grant_id;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a   <= grant_id ? req1_a   : req0_a;
        alu_b   <= grant_id ? req1_b   : req0_b;
        alu_sel <= grant_id ? req1_sel : req0_sel;
        rsp_id  <= grant_id;
      end
      // Carry is captured for logic ops too; the consumer decides whether it matters.
      if (state_q == EXEC) begin
        rsp_data  <= alu_out;
        rsp_carry <= alu_carry;
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed vector table, contention/stall/reset sequences, random scoreboard.
// Expected grant order follows ALU_CTRL_RR_EN in the same way as the design build.
module tb_alu_ctrl;

`ifdef ALU_CTRL_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_sel, req1_sel;
  logic [3:0] alu_a, alu_b, alu_out, rsp_data;
  logic [1:0] alu_sel;
  logic       alu_carry, rsp_valid, rsp_ready, rsp_id, rsp_carry, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .busy(busy)
  );

  // Shared ALU: carry_out is the adder carry regardless of the selected op.
  logic [4:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    case (alu_sel)
      2'd0:    alu_out = alu_a & alu_b;
      2'd1:    alu_out = alu_a | alu_b;
      2'd2:    alu_out = alu_a ^ alu_b;
      default: alu_out = alu_sum[3:0];
    endcase
    alu_carry = alu_sum[4];
  end

  typedef struct {
    bit         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
    logic [3:0] exp_data;
    bit         exp_carry;
  } vec_t;

  typedef struct {
    bit         id;
    logic [3:0] data;
    bit         carry;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    int s;
    logic [3:0] d;
    s = int'(a) + int'(b);
    case (sel)
      2'd0:    d = a & b;
      2'd1:    d = a | b;
      2'd2:    d = a ^ b;
      default: d = 4'(s % 16);
    endcase
    return {s > 15, d};
  endfunction

  task automatic clear_inputs();
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
    rsp_ready  = 0;
  endtask

  task automatic set_req(input bit id, input bit v, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] sel);
    if (id == 1'b0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel;
    end
  endtask

  // Leaves the bench at posedge+1 with rst_n released.
  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {req0_ready, req1_ready}, 0);
    check({tag, "_alu"},   {alu_a, alu_b, alu_sel}, 0);
    check({tag, "_rsp"},   {rsp_valid, rsp_id, rsp_data, rsp_carry}, 0);
    check({tag, "_busy"},  busy, 0);
  endtask

  // Single-requester transaction with rsp_ready high; called and returns at posedge+1.
  task automatic txn(input vec_t v);
    set_req(v.id, 1'b1, v.a, v.b, v.sel);
    rsp_ready = 1;
    @(negedge clk);
    check("txn_ready0", req0_ready, v.id == 1'b0);
    check("txn_ready1", req1_ready, v.id == 1'b1);
    @(posedge clk); #1;
    set_req(v.id, 1'b0, 4'h0, 4'h0, 2'd0);
    @(negedge clk);
    check("txn_exec_busy", {busy, rsp_valid}, 2'b10);
    check("txn_exec_alu", {alu_a, alu_b, alu_sel}, {v.a, v.b, v.sel});
    @(negedge clk);
    check("txn_rsp_valid", rsp_valid, 1);
    check("txn_rsp_data", rsp_data, v.exp_data);
    check("txn_rsp_carry", rsp_carry, v.exp_carry);
    check("txn_rsp_id", rsp_id, v.id);
    @(negedge clk);
    check("txn_idle", {busy, rsp_valid}, 0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[7];
  exp_t q[$];
  bit         v[2], acc[2];
  logic [3:0] ra[2], rb[2];
  logic [1:0] rs[2];
  bit         last, pred;
  int         age, got, ids[4];
  logic [4:0] r;
  exp_t       e;

  initial begin
    vecs[0] = '{1'b0, 4'h3, 4'h1, 2'd3, 4'h4, 1'b0};
    vecs[1] = '{1'b1, 4'hF, 4'h1, 2'd3, 4'h0, 1'b1};
    vecs[2] = '{1'b1, 4'hC, 4'hA, 2'd2, 4'h6, 1'b1};
    vecs[3] = '{1'b0, 4'hC, 4'hA, 2'd0, 4'h8, 1'b1};
    vecs[4] = '{1'b0, 4'h5, 4'h2, 2'd1, 4'h7, 1'b0};
    vecs[5] = '{1'b1, 4'h9, 4'h6, 2'd2, 4'hF, 1'b0};
    vecs[6] = '{1'b0, 4'h8, 4'h8, 2'd3, 4'h0, 1'b1};

    // Reset state, with both requesters asking.
    rst_n = 0;
    clear_inputs();
    req0_valid = 1; req1_valid = 1;
    #3 check_all_zero("reset");
    do_reset();

    // Vector table; the first one lands in the first cycle after reset release.
    foreach (vecs[i]) txn(vecs[i]);

    // Contention: both valid continuously from reset, consumer always ready.
    do_reset();
    set_req(1'b0, 1'b1, 4'h1, 4'h1, 2'd3);
    set_req(1'b1, 1'b1, 4'h2, 4'h2, 2'd3);
    rsp_ready = 1;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        ids[got] = int'(rsp_id);
        got++;
      end
    end
    check("contend_count", got, 4);
    for (int i = 0; i < got; i++)
      check($sformatf("contend_id%0d", i), ids[i], RR ? (i % 2) : 0);
    @(posedge clk); #1;

    // Stalled response with both requesters waiting.
    do_reset();
    set_req(1'b0, 1'b1, 4'h7, 4'h8, 2'd3);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 4'h1, 4'h2, 2'd1);
    set_req(1'b1, 1'b1, 4'h3, 4'h4, 2'd2);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_rsp", {rsp_valid, rsp_id, rsp_data, rsp_carry}, {1'b1, 1'b0, 4'hF, 1'b0});
      check("stall_busy_ready", {busy, req0_ready, req1_ready}, 3'b100);
      check("stall_alu_hold", {alu_a, alu_b, alu_sel}, {4'h7, 4'h8, 2'd3});
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    @(negedge clk);
    check("stall_release_noacc", {rsp_valid, req0_ready, req1_ready}, 3'b100);
    @(negedge clk);
    check("stall_idle", {busy, rsp_valid}, 0);
    check("stall_next_grant", {req0_ready, req1_ready}, RR ? 2'b01 : 2'b10);

    // Reset pulse in EXEC discards the operation.
    do_reset();
    set_req(1'b1, 1'b1, 4'h3, 4'h4, 2'd3);
    rsp_ready = 1;
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 4'h0, 4'h0, 2'd0);
    check("exec_before_reset", busy, 1);
    #2 rst_n = 0;
    req0_valid = 1;
    #1 check_all_zero("reset_exec");
    req0_valid = 0;
    @(posedge clk); #1 rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_reset_quiet", {rsp_valid, busy}, 0);
    end
    @(posedge clk); #1;
    txn(vecs[0]);

    // Random traffic against the transaction-level scoreboard.
    do_reset();
    last = 1'b1;
    age = 0;
    v = '{0, 0};
    acc = '{0, 0};
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (q.size() > 0) age++;
      check("rnd_rsp_valid", rsp_valid, (q.size() > 0) && (age >= 2));
      if (q.size() > 0 && age >= 2) begin
        check("rnd_rsp", {rsp_id, rsp_data, rsp_carry}, {q[0].id, q[0].data, q[0].carry});
      end
      if (q.size() == 0 && (v[0] || v[1])) begin
        pred = (v[0] && v[1]) ? (RR ? ~last : 1'b0) : v[1];
        check("rnd_grant", {req0_ready, req1_ready}, pred ? 2'b01 : 2'b10);
        r = ref_op(ra[pred], rb[pred], rs[pred]);
        e.id = pred; e.data = r[3:0]; e.carry = r[4];
        q.push_back(e);
        acc[pred] = 1;
        last = pred;
        age = 0;
      end else begin
        check("rnd_no_ready", {req0_ready, req1_ready}, 0);
      end
      if (rsp_valid && rsp_ready && q.size() > 0 && age >= 2) void'(q.pop_front());
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i] || !v[i]) begin
          acc[i] = 0;
          v[i]   = ($urandom_range(0, 2) != 0);
          ra[i]  = 4'($urandom);
          rb[i]  = 4'($urandom);
          rs[i]  = 2'($urandom);
        end
        set_req(i[0], v[i], ra[i], rb[i], rs[i]);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
